// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    BRANCH = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational IR decode: recognises addi/bne and extracts register fields.
module instr_decode
  import ctrl_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [D_WIDTH-1:0] ir,
  output logic               is_addi,
  output logic               is_bne,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_upper;

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign rd      = ir[11:7];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign is_addi = (opcode == OPC_OPIMM)  && (funct3 == F3_ADDI);
  assign is_bne  = (opcode == OPC_BRANCH) && (funct3 == F3_BNE);

  // funct7 / immediate bits are consumed by the datapath's immediate generator, not here
  assign unused_upper = ^ir[D_WIDTH-1:25];

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for addi and bne.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int D_WIDTH   = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [D_WIDTH-1:0] instr,
  input  logic               EQ,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic               ALUsrc,
  output logic               ALUctrl,
  output logic               RegWrite,
  output logic               ImmSrc,
  output logic               PCsrc,
  output logic               pc_en,
  output logic               busy,
  output logic               illegal
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] instret
`endif
);

  state_t             state;
  logic [D_WIDTH-1:0] ir;
  logic               is_addi;
  logic               is_bne;
  logic               branch_cyc;

  instr_decode #(.D_WIDTH(D_WIDTH)) u_decode (
    .ir      (ir),
    .is_addi (is_addi),
    .is_bne  (is_bne),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd)
  );

  // EQ is produced by the ALU during the branch cycle itself, so it cannot be registered
  assign PCsrc = branch_cyc & ~EQ;

  // Sequencer: strobes are registered on the transition into the state that owns them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      ir         <= '0;
      imem_req   <= 1'b1;
      busy       <= 1'b1;
      illegal    <= 1'b0;
      ALUsrc     <= 1'b0;
      ALUctrl    <= 1'b0;
      RegWrite   <= 1'b0;
      ImmSrc     <= 1'b0;
      pc_en      <= 1'b0;
      branch_cyc <= 1'b0;
    end else begin
      ALUsrc     <= 1'b0;
      ALUctrl    <= 1'b0;
      RegWrite   <= 1'b0;
      ImmSrc     <= 1'b0;
      pc_en      <= 1'b0;
      branch_cyc <= 1'b0;
      case (state)
        FETCH: begin
          if (imem_ack) begin
            ir       <= instr;
            imem_req <= 1'b0;
            state    <= DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        DECODE: begin
          if (is_addi) begin
            ALUsrc   <= 1'b1;
            RegWrite <= 1'b1;
            pc_en    <= 1'b1;
            state    <= EXEC;
          end else if (is_bne) begin
            ALUctrl    <= 1'b1;
            ImmSrc     <= 1'b1;
            pc_en      <= 1'b1;
            branch_cyc <= 1'b1;
            state      <= BRANCH;
          end else begin
            illegal <= 1'b1;
            busy    <= 1'b0;
            state   <= HALT;
          end
        end
        EXEC, BRANCH: begin
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        HALT: begin
          imem_req <= 1'b0;
          busy     <= 1'b0;
          illegal  <= 1'b1;
          state    <= HALT;
        end
        default: begin
          imem_req <= 1'b0;
          busy     <= 1'b0;
          illegal  <= 1'b1;
          state    <= HALT;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if ((state == EXEC) || (state == BRANCH)) begin
      instret <= instret + CNT_WIDTH'(1);
    end else begin
      instret <= instret;
    end
  end
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and randomized instruction streams
// checked against an instruction-level reference model.
module tb_multicycle_ctrl;

  localparam int DW = 32;
  localparam int CW = 2;

  typedef enum {K_ADDI, K_BNE, K_ILL} kind_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic          imem_ack;
  logic [DW-1:0] instr;
  logic          EQ;
  logic [4:0]    rs1, rs2, rd;
  logic          ALUsrc, ALUctrl, RegWrite, ImmSrc, PCsrc, pc_en, busy, illegal;
`ifdef PERF_CNT_EN
  logic [CW-1:0] instret;
`endif

  int errors = 0;
  int checks = 0;
  int ret_model = 0;

  multicycle_ctrl #(.D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .instr    (instr),
    .EQ       (EQ),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .ALUsrc   (ALUsrc),
    .ALUctrl  (ALUctrl),
    .RegWrite (RegWrite),
    .ImmSrc   (ImmSrc),
    .PCsrc    (PCsrc),
    .pc_en    (pc_en),
    .busy     (busy),
    .illegal  (illegal)
`ifdef PERF_CNT_EN
    ,
    .instret  (instret)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes_now();
    return {ALUsrc, ALUctrl, RegWrite, ImmSrc, PCsrc, pc_en};
  endfunction

  function automatic kind_t classify(input logic [31:0] w);
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return K_ADDI;
    if (w[6:0] == 7'h63 && w[14:12] == 3'd1) return K_BNE;
    return K_ILL;
  endfunction

  // Expected {ALUsrc, ALUctrl, RegWrite, ImmSrc, PCsrc, pc_en} in the execute cycle
  function automatic logic [5:0] strobes_for(input kind_t k, input logic eq);
    case (k)
      K_ADDI:  return 6'b101001;
      K_BNE:   return {4'b0101, ~eq, 1'b1};
      default: return 6'b000000;
    endcase
  endfunction

  task automatic check_counter();
`ifdef PERF_CNT_EN
    chk("instret", 32'(instret), 32'(ret_model));
`endif
  endtask

  task automatic run_instr(input logic [31:0] w, input logic eq, input int waits);
    kind_t k;
    k = classify(w);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_strobes", 32'(strobes_now()), 32'd0);
      imem_ack = 1'b0;
      instr    = $urandom;
    end
    @(negedge clk);
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_busy", 32'(busy), 32'd1);
    chk("fetch_strobes", 32'(strobes_now()), 32'd0);
    check_counter();
    imem_ack = 1'b1;
    instr    = w;
    @(negedge clk);
    imem_ack = 1'($urandom_range(0, 1));
    instr    = $urandom;
    EQ       = eq;
    chk("decode_req", 32'(imem_req), 32'd0);
    chk("decode_strobes", 32'(strobes_now()), 32'd0);
    chk("decode_rd", 32'(rd), 32'(w[11:7]));
    chk("decode_rs1", 32'(rs1), 32'(w[19:15]));
    chk("decode_rs2", 32'(rs2), 32'(w[24:20]));
    @(negedge clk);
    imem_ack = 1'b0;
    chk("exec_strobes", 32'(strobes_now()), 32'(strobes_for(k, eq)));
    chk("exec_rd", 32'(rd), 32'(w[11:7]));
    chk("exec_rs1", 32'(rs1), 32'(w[19:15]));
    chk("exec_req", 32'(imem_req), 32'd0);
    chk("exec_illegal", 32'(illegal), (k == K_ILL) ? 32'd1 : 32'd0);
    chk("exec_busy", 32'(busy), (k == K_ILL) ? 32'd0 : 32'd1);
    if (k != K_ILL) ret_model = (ret_model + 1) % (1 << CW);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_strobes", 32'(strobes_now()), 32'd0);
    chk("rst_fields", 32'({rs1, rs2, rd}), 32'd0);
    rst       = 1'b0;
    ret_model = 0;
  endtask

  initial begin
    logic [31:0] w;
    rst      = 1'b1;
    imem_ack = 1'b0;
    instr    = 32'd0;
    EQ       = 1'b0;
    do_reset();
    check_counter();

    // Directed instructions
    run_instr(32'h00500513, 1'b0, 0);
    run_instr(32'hFE051EE3, 1'b0, 0);
    run_instr(32'hFE051EE3, 1'b1, 0);
    run_instr(32'h00500513, 1'b1, 4);

    // Randomized addi/bne stream with random ack delays
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1)
        w = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h13};
      else
        w = {7'($urandom), 5'($urandom), 5'($urandom), 3'b001, 5'($urandom), 7'h63};
      run_instr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Unsupported encoding halts until reset
    run_instr(32'h00000033, 1'b0, 0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      imem_ack = ~imem_ack;
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_illegal", 32'(illegal), 32'd1);
      chk("halt_strobes", 32'(strobes_now()), 32'd0);
    end
    do_reset();

    // Random illegal encoding
    do w = $urandom; while (classify(w) != K_ILL);
    run_instr(w, 1'b0, 1);
    do_reset();

    // Asynchronous reset while an addi is in DECODE
    run_instr(32'h00500513, 1'b0, 0);
    @(negedge clk);
    imem_ack = 1'b1;
    instr    = 32'h00500513;
    @(negedge clk);
    imem_ack = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_req", 32'(imem_req), 32'd1);
    chk("async_strobes", 32'(strobes_now()), 32'd0);
    @(negedge clk);
    chk("async_hold_strobes", 32'(strobes_now()), 32'd0);
    chk("async_fields", 32'({rs1, rs2, rd}), 32'd0);
    rst       = 1'b0;
    ret_model = 0;
    for (int n = 0; n < 5; n++) run_instr(32'h00500513 + (32'(n) << 7), 1'b0, n % 2);
    @(negedge clk);
    check_counter();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
